// File: rtl/alu_reg_iq.sv
// Age-ordered issue queue for ALU reg-reg ops, waking operands from the banked writeback bus.
// Optional perf counters are enabled with `define ALU_REG_IQ_PERF_EN.

package core_types_pkg;
  localparam int unsigned LOG_PR_COUNT       = 7;
  localparam int unsigned LOG_PRF_BANK_COUNT = 2;
  localparam int unsigned PRF_BANK_COUNT     = 4;
  localparam int unsigned LOG_ROB_ENTRIES    = 7;

  typedef struct packed {
    logic [3:0]                 op;
    logic [LOG_PR_COUNT-1:0]    a_pr;
    logic [LOG_PR_COUNT-1:0]    b_pr;
    logic                       a_ready;
    logic                       b_ready;
    logic                       a_zero;
    logic                       b_zero;
    logic [LOG_PR_COUNT-1:0]    dest_pr;
    logic [LOG_ROB_ENTRIES-1:0] rob_index;
  } alu_reg_iq_entry_t;
endpackage

module alu_reg_iq
  import core_types_pkg::*;
#(
  parameter int unsigned ALU_REG_IQ_ENTRIES = 8
) (
  input  logic                                 CLK,
  input  logic                                 RST,
`ifdef ALU_REG_IQ_PERF_EN
  output logic [31:0]                          perf_issue_count,
  output logic [31:0]                          perf_full_cycles,
`endif
  input  logic                                 dispatch_valid,
  input  logic [3:0]                           dispatch_op,
  input  logic [LOG_PR_COUNT-1:0]              dispatch_A_PR,
  input  logic                                 dispatch_A_ready,
  input  logic                                 dispatch_A_is_zero,
  input  logic [LOG_PR_COUNT-1:0]              dispatch_B_PR,
  input  logic                                 dispatch_B_ready,
  input  logic                                 dispatch_B_is_zero,
  input  logic [LOG_PR_COUNT-1:0]              dispatch_dest_PR,
  input  logic [LOG_ROB_ENTRIES-1:0]           dispatch_ROB_index,
  output logic                                 dispatch_ready,
  input  logic [PRF_BANK_COUNT-1:0]            WB_bus_valid_by_bank,
  input  logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] WB_bus_upper_PR_by_bank,
  input  logic                                 pipeline_ready,
  output logic                                 issue_valid,
  output logic [3:0]                           issue_op,
  output logic                                 issue_A_forward,
  output logic                                 issue_A_is_zero,
  output logic [LOG_PRF_BANK_COUNT-1:0]        issue_A_bank,
  output logic                                 issue_B_forward,
  output logic                                 issue_B_is_zero,
  output logic [LOG_PRF_BANK_COUNT-1:0]        issue_B_bank,
  output logic [LOG_PR_COUNT-1:0]              issue_dest_PR,
  output logic [LOG_ROB_ENTRIES-1:0]           issue_ROB_index,
  output logic                                 PRF_req_A_valid,
  output logic [LOG_PR_COUNT-1:0]              PRF_req_A_PR,
  output logic                                 PRF_req_B_valid,
  output logic [LOG_PR_COUNT-1:0]              PRF_req_B_PR
);

  localparam int unsigned N       = ALU_REG_IQ_ENTRIES;
  localparam int unsigned IDX_W   = $clog2(ALU_REG_IQ_ENTRIES);
  localparam int unsigned CNT_W   = $clog2(ALU_REG_IQ_ENTRIES) + 1;
  localparam int unsigned LB      = LOG_PRF_BANK_COUNT;
  localparam int unsigned UPPER_W = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

  alu_reg_iq_entry_t entries_q [N];
  alu_reg_iq_entry_t entries_d [N];
  alu_reg_iq_entry_t woken     [N+1];
  alu_reg_iq_entry_t sel_e;
  alu_reg_iq_entry_t disp_e;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_after;
  logic [N-1:0]     wake_a;
  logic [N-1:0]     wake_b;
  logic [N-1:0]     issuable;
  logic [IDX_W-1:0] sel_idx;
  logic             any_issuable;
  logic             dispatch_fire;

  // A PR wakes when its bank broadcasts a matching upper part this cycle.
  function automatic logic pr_wake(input logic [LOG_PR_COUNT-1:0] pr,
                                   input logic [PRF_BANK_COUNT-1:0] vld,
                                   input logic [PRF_BANK_COUNT-1:0][UPPER_W-1:0] upper);
    logic [LB-1:0] bank;
    bank = pr[LB-1:0];
    return vld[bank] && (upper[bank] == pr[LOG_PR_COUNT-1:LB]);
  endfunction

  assign dispatch_ready = (count_q < CNT_W'(N));
  assign issue_valid    = any_issuable & pipeline_ready;

  // Wakeup and oldest-first select; index 0 holds the oldest entry.
  always_comb begin : wake_select
    wake_a       = '0;
    wake_b       = '0;
    issuable     = '0;
    sel_idx      = '0;
    any_issuable = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      wake_a[i]   = pr_wake(entries_q[i].a_pr, WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank);
      wake_b[i]   = pr_wake(entries_q[i].b_pr, WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank);
      issuable[i] = (CNT_W'(i) < count_q)
                    && (entries_q[i].a_ready || entries_q[i].a_zero || wake_a[i])
                    && (entries_q[i].b_ready || entries_q[i].b_zero || wake_b[i]);
    end
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (issuable[i]) begin
        any_issuable = 1'b1;
        sel_idx      = IDX_W'(i);
      end
    end
  end

  always_comb begin : issue_outputs
    sel_e           = entries_q[sel_idx];
    issue_op        = '0;
    issue_A_forward = 1'b0;
    issue_A_is_zero = 1'b0;
    issue_A_bank    = '0;
    issue_B_forward = 1'b0;
    issue_B_is_zero = 1'b0;
    issue_B_bank    = '0;
    issue_dest_PR   = '0;
    issue_ROB_index = '0;
    PRF_req_A_valid = 1'b0;
    PRF_req_A_PR    = '0;
    PRF_req_B_valid = 1'b0;
    PRF_req_B_PR    = '0;
    if (issue_valid) begin
      issue_op        = sel_e.op;
      issue_A_forward = ~sel_e.a_ready & ~sel_e.a_zero & wake_a[sel_idx];
      issue_A_is_zero = sel_e.a_zero;
      issue_A_bank    = sel_e.a_pr[LB-1:0];
      issue_B_forward = ~sel_e.b_ready & ~sel_e.b_zero & wake_b[sel_idx];
      issue_B_is_zero = sel_e.b_zero;
      issue_B_bank    = sel_e.b_pr[LB-1:0];
      issue_dest_PR   = sel_e.dest_pr;
      issue_ROB_index = sel_e.rob_index;
      PRF_req_A_valid = sel_e.a_ready & ~sel_e.a_zero;
      PRF_req_A_PR    = sel_e.a_pr;
      PRF_req_B_valid = sel_e.b_ready & ~sel_e.b_zero;
      PRF_req_B_PR    = sel_e.b_pr;
    end
  end

  // Capture wakeups, compact over the issued slot, then append the dispatched op.
  always_comb begin : next_state
    dispatch_fire = dispatch_valid & dispatch_ready;
    count_after   = count_q - CNT_W'(issue_valid);
    for (int i = 0; i < int'(N); i++) begin
      woken[i]         = entries_q[i];
      woken[i].a_ready = entries_q[i].a_ready | wake_a[i];
      woken[i].b_ready = entries_q[i].b_ready | wake_b[i];
    end
    woken[N] = '0;
    for (int i = 0; i < int'(N); i++) begin
      entries_d[i] = (issue_valid && (IDX_W'(i) >= sel_idx)) ? woken[i+1] : woken[i];
    end
    disp_e.op        = dispatch_op;
    disp_e.a_pr      = dispatch_A_PR;
    disp_e.b_pr      = dispatch_B_PR;
    disp_e.a_ready   = dispatch_A_ready
                       | pr_wake(dispatch_A_PR, WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank);
    disp_e.b_ready   = dispatch_B_ready
                       | pr_wake(dispatch_B_PR, WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank);
    disp_e.a_zero    = dispatch_A_is_zero;
    disp_e.b_zero    = dispatch_B_is_zero;
    disp_e.dest_pr   = dispatch_dest_PR;
    disp_e.rob_index = dispatch_ROB_index;
    if (dispatch_fire) begin
      entries_d[count_after[IDX_W-1:0]] = disp_e;
    end
    count_d = count_after + CNT_W'(dispatch_fire);
  end

  always_ff @(posedge CLK or posedge RST) begin : state_regs
    if (RST) begin
      count_q <= '0;
      for (int i = 0; i < int'(N); i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

`ifdef ALU_REG_IQ_PERF_EN
  logic [31:0] perf_issue_q;
  logic [31:0] perf_full_q;

  always_ff @(posedge CLK or posedge RST) begin : perf_regs
    if (RST) begin
      perf_issue_q <= '0;
      perf_full_q  <= '0;
    end else begin
      perf_issue_q <= perf_issue_q + 32'(issue_valid);
      perf_full_q  <= perf_full_q + 32'(~dispatch_ready);
    end
  end

  assign perf_issue_count = perf_issue_q;
  assign perf_full_cycles = perf_full_q;
`endif

endmodule

// File: tb/tb_alu_reg_iq.sv
// Bench for alu_reg_iq: directed scenarios plus random traffic checked against a queue-based model.
module tb_alu_reg_iq;
  import core_types_pkg::*;

  logic                                CLK;
  logic                                RST;
  logic                                dispatch_valid;
  logic [3:0]                          dispatch_op;
  logic [LOG_PR_COUNT-1:0]             dispatch_A_PR;
  logic                                dispatch_A_ready;
  logic                                dispatch_A_is_zero;
  logic [LOG_PR_COUNT-1:0]             dispatch_B_PR;
  logic                                dispatch_B_ready;
  logic                                dispatch_B_is_zero;
  logic [LOG_PR_COUNT-1:0]             dispatch_dest_PR;
  logic [LOG_ROB_ENTRIES-1:0]          dispatch_ROB_index;
  logic                                dispatch_ready;
  logic [PRF_BANK_COUNT-1:0]           WB_bus_valid_by_bank;
  logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] WB_bus_upper_PR_by_bank;
  logic                                pipeline_ready;
  logic                                issue_valid;
  logic [3:0]                          issue_op;
  logic                                issue_A_forward;
  logic                                issue_A_is_zero;
  logic [LOG_PRF_BANK_COUNT-1:0]       issue_A_bank;
  logic                                issue_B_forward;
  logic                                issue_B_is_zero;
  logic [LOG_PRF_BANK_COUNT-1:0]       issue_B_bank;
  logic [LOG_PR_COUNT-1:0]             issue_dest_PR;
  logic [LOG_ROB_ENTRIES-1:0]          issue_ROB_index;
  logic                                PRF_req_A_valid;
  logic [LOG_PR_COUNT-1:0]             PRF_req_A_PR;
  logic                                PRF_req_B_valid;
  logic [LOG_PR_COUNT-1:0]             PRF_req_B_PR;
`ifdef ALU_REG_IQ_PERF_EN
  logic [31:0]                         perf_issue_count;
  logic [31:0]                         perf_full_cycles;
  int                                  m_perf_issue;
  int                                  m_perf_full;
`endif

  int checks;
  int errors;

  typedef struct {
    int op;
    int a_pr;
    int b_pr;
    bit a_rdy;
    bit b_rdy;
    bit a_z;
    bit b_z;
    int dest;
    int rob;
  } mop_t;

  mop_t q[$];

  alu_reg_iq #(.ALU_REG_IQ_ENTRIES(8)) dut (
    .CLK                     (CLK),
    .RST                     (RST),
`ifdef ALU_REG_IQ_PERF_EN
    .perf_issue_count        (perf_issue_count),
    .perf_full_cycles        (perf_full_cycles),
`endif
    .dispatch_valid          (dispatch_valid),
    .dispatch_op             (dispatch_op),
    .dispatch_A_PR           (dispatch_A_PR),
    .dispatch_A_ready        (dispatch_A_ready),
    .dispatch_A_is_zero      (dispatch_A_is_zero),
    .dispatch_B_PR           (dispatch_B_PR),
    .dispatch_B_ready        (dispatch_B_ready),
    .dispatch_B_is_zero      (dispatch_B_is_zero),
    .dispatch_dest_PR        (dispatch_dest_PR),
    .dispatch_ROB_index      (dispatch_ROB_index),
    .dispatch_ready          (dispatch_ready),
    .WB_bus_valid_by_bank    (WB_bus_valid_by_bank),
    .WB_bus_upper_PR_by_bank (WB_bus_upper_PR_by_bank),
    .pipeline_ready          (pipeline_ready),
    .issue_valid             (issue_valid),
    .issue_op                (issue_op),
    .issue_A_forward         (issue_A_forward),
    .issue_A_is_zero         (issue_A_is_zero),
    .issue_A_bank            (issue_A_bank),
    .issue_B_forward         (issue_B_forward),
    .issue_B_is_zero         (issue_B_is_zero),
    .issue_B_bank            (issue_B_bank),
    .issue_dest_PR           (issue_dest_PR),
    .issue_ROB_index         (issue_ROB_index),
    .PRF_req_A_valid         (PRF_req_A_valid),
    .PRF_req_A_PR            (PRF_req_A_PR),
    .PRF_req_B_valid         (PRF_req_B_valid),
    .PRF_req_B_PR            (PRF_req_B_PR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_wake(int pr);
    int b;
    b = pr % int'(PRF_BANK_COUNT);
    return WB_bus_valid_by_bank[b] && (int'(WB_bus_upper_PR_by_bank[b]) == pr / int'(PRF_BANK_COUNT));
  endfunction

  function automatic bit m_avail(mop_t e);
    return (e.a_rdy || e.a_z || m_wake(e.a_pr)) && (e.b_rdy || e.b_z || m_wake(e.b_pr));
  endfunction

  function automatic logic [63:0] exp_bundle(mop_t e);
    bit fa;
    bit fb;
    fa = !e.a_rdy && !e.a_z && m_wake(e.a_pr);
    fb = !e.b_rdy && !e.b_z && m_wake(e.b_pr);
    return {22'd0, 4'(e.op), fa, e.a_z, 2'(e.a_pr % 4), fb, e.b_z, 2'(e.b_pr % 4),
            7'(e.dest), 7'(e.rob), (e.a_rdy && !e.a_z), 7'(e.a_pr),
            (e.b_rdy && !e.b_z), 7'(e.b_pr)};
  endfunction

  function automatic logic [63:0] obs_bundle();
    return {22'd0, issue_op, issue_A_forward, issue_A_is_zero, issue_A_bank,
            issue_B_forward, issue_B_is_zero, issue_B_bank, issue_dest_PR, issue_ROB_index,
            PRF_req_A_valid, PRF_req_A_PR, PRF_req_B_valid, PRF_req_B_PR};
  endfunction

  task automatic disp(int op, int a, int b, bit ar, bit br, bit az, bit bz, int dest, int rob);
    dispatch_valid     = 1'b1;
    dispatch_op        = 4'(op);
    dispatch_A_PR      = 7'(a);
    dispatch_B_PR      = 7'(b);
    dispatch_A_ready   = ar;
    dispatch_B_ready   = br;
    dispatch_A_is_zero = az;
    dispatch_B_is_zero = bz;
    dispatch_dest_PR   = 7'(dest);
    dispatch_ROB_index = 7'(rob);
  endtask

  task automatic wb_pr(int pr);
    WB_bus_valid_by_bank[pr % 4]    = 1'b1;
    WB_bus_upper_PR_by_bank[pr % 4] = 5'(pr / 4);
  endtask

  // Check outputs against the model, advance the model, then take one clock edge.
  task automatic cycle();
    int   k;
    bit   exp_iv;
    bit   exp_dr;
    bit   fire;
    mop_t e;
    logic [63:0] exp_b;
    #1;
    k = -1;
    foreach (q[i]) if (k < 0 && m_avail(q[i])) k = i;
    exp_dr = (q.size() < 8);
    exp_iv = (k >= 0) && pipeline_ready;
    chk("dispatch_ready", 64'(dispatch_ready), 64'(exp_dr));
    chk("issue_valid", 64'(issue_valid), 64'(exp_iv));
    exp_b = '0;
    if (exp_iv) exp_b = exp_bundle(q[k]);
    chk("issue_fields", obs_bundle(), exp_b);
`ifdef ALU_REG_IQ_PERF_EN
    chk("perf_issue_count", 64'(perf_issue_count), 64'(m_perf_issue));
    chk("perf_full_cycles", 64'(perf_full_cycles), 64'(m_perf_full));
    if (exp_iv) m_perf_issue++;
    if (!exp_dr) m_perf_full++;
`endif
    fire = dispatch_valid && (q.size() < 8);
    if (exp_iv) q.delete(k);
    foreach (q[i]) begin
      q[i].a_rdy = q[i].a_rdy || m_wake(q[i].a_pr);
      q[i].b_rdy = q[i].b_rdy || m_wake(q[i].b_pr);
    end
    if (fire) begin
      e.op    = int'(dispatch_op);
      e.a_pr  = int'(dispatch_A_PR);
      e.b_pr  = int'(dispatch_B_PR);
      e.a_rdy = dispatch_A_ready || m_wake(e.a_pr);
      e.b_rdy = dispatch_B_ready || m_wake(e.b_pr);
      e.a_z   = dispatch_A_is_zero;
      e.b_z   = dispatch_B_is_zero;
      e.dest  = int'(dispatch_dest_PR);
      e.rob   = int'(dispatch_ROB_index);
      q.push_back(e);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
`ifdef ALU_REG_IQ_PERF_EN
    m_perf_issue = 0;
    m_perf_full  = 0;
`endif
    RST = 1'b1;
    dispatch_valid = 1'b0;
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    dispatch_valid = 1'b0;
    WB_bus_valid_by_bank = '0;
    WB_bus_upper_PR_by_bank = '0;
    pipeline_ready = 1'b0;
    #2;
    chk("reset_dispatch_ready", 64'(dispatch_ready), 64'd1);
    chk("reset_issue_valid", 64'(issue_valid), 64'd0);
    chk("reset_fields", obs_bundle(), 64'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Ready A, zero B: issues one cycle after dispatch.
    pipeline_ready = 1'b1;
    disp(0, 5, 3, 1, 0, 0, 1, 9, 3);
    cycle();
    dispatch_valid = 1'b0;
    #1;
    chk("tp1_issue_valid", 64'(issue_valid), 64'd1);
    chk("tp1_A_bank", 64'(issue_A_bank), 64'd1);
    chk("tp1_B_is_zero", 64'(issue_B_is_zero), 64'd1);
    chk("tp1_reqA", 64'({PRF_req_A_valid, PRF_req_A_PR}), 64'({1'b1, 7'd5}));
    chk("tp1_reqB_valid", 64'(PRF_req_B_valid), 64'd0);
    chk("tp1_dest", 64'(issue_dest_PR), 64'd9);
    cycle();
    cycle();

    // A waits for a broadcast two cycles later and issues forwarded.
    disp(2, 12, 20, 0, 1, 0, 0, 14, 4);
    cycle();
    dispatch_valid = 1'b0;
    cycle();
    wb_pr(12);
    #1;
    chk("tp2_A_forward", 64'(issue_A_forward), 64'd1);
    chk("tp2_reqA_valid", 64'(PRF_req_A_valid), 64'd0);
    chk("tp2_reqB_valid", 64'(PRF_req_B_valid), 64'd1);
    cycle();
    WB_bus_valid_by_bank = '0;
    cycle();

    // Fill all 8 entries while stalled; a 9th offer is ignored.
    pipeline_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      disp(1, 16 + i, 24 + i, 1, 1, 0, 0, 50 + i, i);
      cycle();
    end
    dispatch_valid = 1'b0;
    chk("tp3_full", 64'(dispatch_ready), 64'd0);
    pipeline_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("tp3_order", 64'(issue_ROB_index), 64'(i));
      cycle();
    end
    cycle();

    // Older waiting entry beats a younger ready one once woken.
    pipeline_ready = 1'b0;
    disp(3, 30, 0, 0, 0, 0, 1, 60, 10);
    cycle();
    disp(4, 31, 33, 1, 1, 0, 0, 61, 11);
    cycle();
    disp(5, 40, 41, 0, 1, 0, 0, 62, 12);
    cycle();
    dispatch_valid = 1'b0;
    pipeline_ready = 1'b1;
    wb_pr(30);
    #1;
    chk("tp4_first", 64'({issue_ROB_index, issue_A_forward}), 64'({7'd10, 1'b1}));
    cycle();
    WB_bus_valid_by_bank = '0;
    #1;
    chk("tp4_second", 64'(issue_ROB_index), 64'd11);
    cycle();
    cycle();
    wb_pr(40);
    #1;
    chk("tp4_third", 64'({issue_ROB_index, issue_A_forward}), 64'({7'd12, 1'b1}));
    cycle();
    WB_bus_valid_by_bank = '0;
    cycle();

    // Broadcast in the dispatch cycle is captured as ready, not forwarded.
    disp(6, 44, 0, 0, 0, 0, 1, 63, 20);
    wb_pr(44);
    cycle();
    dispatch_valid = 1'b0;
    WB_bus_valid_by_bank = '0;
    #1;
    chk("tp5_forward", 64'(issue_A_forward), 64'd0);
    chk("tp5_reqA", 64'({PRF_req_A_valid, PRF_req_A_PR}), 64'({1'b1, 7'd44}));
    cycle();

    // Reset with 5 queued ops drops them all at once.
    pipeline_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      disp(7, 2 * i, 2 * i + 1, 1, 1, 0, 0, 70 + i, 30 + i);
      cycle();
    end
    dispatch_valid = 1'b0;
    cycle();
    pipeline_ready = 1'b1;
    RST = 1'b1;
    #1;
    chk("rst_dispatch_ready", 64'(dispatch_ready), 64'd1);
    chk("rst_issue_valid", 64'(issue_valid), 64'd0);
    chk("rst_fields", obs_bundle(), 64'd0);
`ifdef ALU_REG_IQ_PERF_EN
    chk("rst_perf_issue", 64'(perf_issue_count), 64'd0);
    chk("rst_perf_full", 64'(perf_full_cycles), 64'd0);
    m_perf_issue = 0;
    m_perf_full  = 0;
`endif
    q.delete();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    cycle();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      pipeline_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 6)
        disp(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0),
             int'($urandom_range(0, 127)), n % 128);
      else
        dispatch_valid = 1'b0;
      for (int b = 0; b < 4; b++) begin
        WB_bus_valid_by_bank[b]    = ($urandom_range(0, 3) == 0);
        WB_bus_upper_PR_by_bank[b] = 5'($urandom_range(0, 3));
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
